// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// It accepts a read or write, waits LATENCY cycles and then completes the access.
// Ports:
//   clk, rst (async, active-high)
//   mem_read, mem_write, address, write_data  - request, held until ready
//   read_data, ready                          - one-cycle completion pulse
//   stall                                     - combinational pipeline hold
// Optional macro DMEM_ERR_EN adds an err output. It flags misaligned accesses
// and requests that assert read and write together.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        stall
`ifdef DMEM_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               ready_q, ready_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               bad_q, bad_d;
  logic               err_q, err_d;
  logic               mem_we;
  logic               req;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic unused_addr;
  assign unused_addr = ^{address[31:IDX_W+2], address[1:0]};

  assign req = mem_read | mem_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    rdata_d = rdata_q;
    bad_d   = bad_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          // Read and write together counts as a write.
          wr_d    = mem_write;
          idx_d   = address[IDX_W+1:2];
          wdata_d = write_data;
          cnt_d   = CNT_W'(LATENCY - 1);
`ifdef DMEM_ERR_EN
          bad_d   = (|address[1:0]) |
                    (mem_read & mem_write);
`else
          bad_d   = 1'b0;
`endif
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (!bad_q) begin
            if (wr_q) mem_we = 1'b1;
            else rdata_d = mem_q[idx_q];
          end
          ready_d = 1'b1;
          err_d   = bad_q;
          state_d = RESP;
        end
      end
      RESP: begin
        ready_d = 1'b0;
        rdata_d = '0;
        err_d   = 1'b0;
        wr_d    = 1'b0;
        bad_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
    end
  end

  // The array is not reset. An async reset forces state_q to IDLE, so no
  // write can commit while rst is high.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign read_data = rdata_q;
  assign ready     = ready_q;
  assign stall     = req & ~ready_q;

`ifdef DMEM_ERR_EN
  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random self-checking bench.
// It checks dmem_responder against an array-based reference model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        stall;
`ifdef DMEM_ERR_EN
  logic        err;
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] model [DEPTH];

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .stall(stall)
`ifdef DMEM_ERR_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_err(input string tag, input logic exp);
`ifdef DMEM_ERR_EN
    check(tag, {31'b0, err}, {31'b0, exp});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    check("idle_ready", {31'b0, ready}, 32'd0);
    check("idle_stall", {31'b0, stall}, 32'd0);
    check("idle_rdata", read_data, 32'd0);
    check_err("idle_err", 1'b0);
  endtask

  // mode 0: hold request; 1: change addr/data during WAIT; 2: drop request during WAIT
  task automatic access(input bit rd, input bit wr,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input int mode);
    int idx;
    bit bad;
    logic [31:0] exp;
    idx = int'((a >> 2) % DEPTH);
    bad = ERR_EN && ((a[1:0] != 2'b00) || (rd && wr));
    exp = (rd && !wr && !bad) ? model[idx] : 32'd0;
    step();
    mem_read   = rd;
    mem_write  = wr;
    address    = a;
    write_data = d;
    #1;
    check("acc_stall_T", {31'b0, stall}, 32'd1);
    check("acc_rdata_T", read_data, 32'd0);
    for (int i = 1; i <= LAT; i++) begin
      step();
      if (mode == 1) begin
        address    = a + 32'd4;
        write_data = ~d;
      end
      if (mode == 2) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      #1;
      check("acc_stall_wait", {31'b0, stall},
            (mode == 2) ? 32'd0 : 32'd1);
      check("acc_ready_wait", {31'b0, ready}, 32'd0);
    end
    step();
    #1;
    check("acc_ready_resp", {31'b0, ready}, 32'd1);
    check("acc_stall_resp", {31'b0, stall}, 32'd0);
    check("acc_rdata_resp", read_data, exp);
    check_err("acc_err_resp", bad);
    if (wr && !bad) model[idx] = d;
  endtask

  logic [31:0] ra;
  logic [31:0] rdv;
  int          op;

  initial begin
    rst        = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = '0;
    write_data = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    #1;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check_err("rst_err", 1'b0);
    step();
    step();
    rst = 1'b0;

    // Zero-init preload through the port
    for (int i = 0; i < DEPTH; i++)
      access(1'b0, 1'b1, 32'(i * 4), 32'd0, 0);
    idle();

    // Fresh read, then write/read back to back
    access(1'b1, 1'b0, 32'h10, 32'd0, 0);
    idle();
    access(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 0);
    access(1'b1, 1'b0, 32'h20, 32'd0, 0);
    idle();

    // Wrap: 0x400 aliases word 0
    access(1'b0, 1'b1, 32'h000, 32'hA5A5_0F0F, 0);
    access(1'b1, 1'b0, 32'h400, 32'd0, 0);
    idle();

    // Reset in the second WAIT cycle of a write
    access(1'b0, 1'b1, 32'h40, 32'h1111_1111, 0);
    idle();
    step();
    mem_write  = 1'b1;
    address    = 32'h40;
    write_data = 32'h12345678;
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'b0, ready}, 32'd0);
    check("midrst_rdata", read_data, 32'd0);
    mem_write = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("midrst_stall", {31'b0, stall}, 32'd0);
    access(1'b1, 1'b0, 32'h40, 32'd0, 0);
    idle();

    // Address change during WAIT is ignored
    access(1'b0, 1'b1, 32'h10, 32'h0000_1010, 0);
    access(1'b0, 1'b1, 32'h14, 32'h0000_1414, 0);
    access(1'b1, 1'b0, 32'h10, 32'd0, 1);
    access(1'b0, 1'b1, 32'h18, 32'h0000_1818, 1);
    access(1'b1, 1'b0, 32'h18, 32'd0, 0);
    access(1'b1, 1'b0, 32'h1C, 32'd0, 0);
    idle();

    // Read and write together, then read back
    access(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 0);
    access(1'b1, 1'b0, 32'h30, 32'd0, 0);
    idle();

    // Misaligned write, then check the word it would have hit
    access(1'b0, 1'b1, 32'h22, 32'h5555_AAAA, 0);
    idle();
    access(1'b1, 1'b0, 32'h20, 32'd0, 0);

    // Drop request during WAIT: stall falls, access still completes
    access(1'b1, 1'b0, 32'h20, 32'd0, 2);
    idle();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      ra = 32'($urandom_range(0, 2047));
      if (ERR_EN && ($urandom_range(0, 3) != 0)) ra[1:0] = 2'b00;
      rdv = $urandom;
      op  = int'($urandom_range(0, 7));
      if (op == 0) access(1'b1, 1'b1, ra, rdv, 0);
      else if (op < 4) access(1'b0, 1'b1, ra, rdv,
                              int'($urandom_range(0, 2)));
      else access(1'b1, 1'b0, ra, rdv,
                  int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port.
- Accepts the MEM-stage request (mem_read or mem_write, with address and write data) and completes it after a fixed number of wait cycles.
- Returns read data with a one-cycle ready pulse.
- Drives a combinational stall so the pipeline holds in MEM while an access is outstanding.
- Replaces the zero-wait data memory wherever multi-cycle memory timing is modelled.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the array. Must be a power of two.
- LATENCY, 2: number of WAIT cycles between acceptance and completion. Range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  read request; held by the requester until ready.
- mem_write  in  1  write request; held by the requester until ready.
- address  in  32  byte address; word index is address[log2(DEPTH_WORDS)+1:2].
- write_data  in  32  store data.
- read_data  out  32  load data; valid only while ready=1.
- ready  out  1  one-cycle completion pulse.
- stall  out  1  combinational: (mem_read | mem_write) & ~ready.

Behaviour:
- Reset:
  - Asynchronous on rst=1: state=IDLE, cnt=0, ready=0, read_data=0, captured request cleared.
  - Array contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write: capture op, word index and write_data; cnt<=LATENCY-1; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If cnt!=0: cnt<=cnt-1 and stay in WAIT.
  - If cnt==0, on that edge:
    - write: mem[idx]<=data.
    - read: read_data<=mem[idx].
    - ready<=1; go to RESP.
- RESP:
  - ready=1 for exactly this cycle.
  - Next edge: ready<=0, read_data<=0, go to IDLE.
  - Any request during RESP is ignored.
- Latency: a request first seen in IDLE at cycle T gives ready=1 in cycle T+LATENCY+1. Back-to-back accesses are therefore spaced LATENCY+2 cycles apart.
- Handshake:
  - The requester samples ready at the edge ending RESP and presents its next request (or none) from the following cycle onward.
  - Changes to request inputs during WAIT are ignored; the captured values are used.
- Simultaneous mem_read=1 and mem_write=1: treated as a write. read_data stays 0 in RESP.
- Address:
  - Bits above the index wrap modulo DEPTH_WORDS.
  - Bits [1:0] are ignored unless DMEM_ERR_EN is defined.
- Reset mid-access: an in-flight write is not committed; outputs return to reset values immediately.
- stall is purely combinational. It is 0 whenever no request is present, independent of state.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - A request with address[1:0]!=0, or with both mem_read and mem_write asserted, is accepted and timed normally.
  - At completion it does not touch the array, read_data=0, and err=1 together with ready for the RESP cycle.
  - err is 0 in all other cycles.
- Undefined: no err port; address[1:0] are ignored; both-asserted is treated as a write.

Test Plan:
- Reset, then hold mem_read=1, address=0x10 with LATENCY=2 -> stall=1 for cycles T..T+2; ready=1 and stall=0 at T+3; read_data=0x00000000 on a fresh array after a zero-init preload.
- Write 0xDEADBEEF to 0x20, then read 0x20 -> the read returns 0xDEADBEEF; ready pulses once per access; second request accepted 4 cycles after the first.
- Read address 0x400 with DEPTH_WORDS=256 -> wraps to word 0; data equals the word written at 0x000.
- Assert rst in the second WAIT cycle of a write of 0x12345678 to 0x40 -> ready=0 immediately; a subsequent read of 0x40 returns the old value.
- Change address from 0x10 to 0x14 during WAIT -> the access still targets 0x10. Assert mem_read and mem_write together -> a write occurs and read_data=0.
- With DMEM_ERR_EN, write to 0x22 -> err=1 with ready; word 0x20 unchanged; err=0 on the following cycle.
